ram_arbiter: RTL and testbench

- Shares the single-port 1024x8 main memory (RAM) between two requesters: the processor core (CPU port) and a bulk loader/debug engine (DMA port).
- Round-robin arbitration, with an optional DMA burst lock that has a bounded hold.
- Each granted request is registered onto the RAM enable/write/address/data lines for exactly one cycle. Read data is returned to the winner with a one-cycle valid pulse.
- Sits between the control unit's RAM interface and the main memory instance.

---
 rtl/ram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ram_arbiter
// Description : Round-robin CPU/DMA arbiter for the single-port main memory,
//               with a bounded DMA burst lock and registered RAM strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] c_LOCK_MAX = 4'(LOCK_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ram_en,     w_ram_en_nxt;
    logic              r_ram_we,     w_ram_we_nxt;
    logic [ADDR_W-1:0] r_ram_addr,   w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_wdata,  w_ram_wdata_nxt;
    logic              r_cpu_gnt,    w_cpu_gnt_nxt;
    logic              r_dma_gnt,    w_dma_gnt_nxt;
    logic              r_cpu_rvalid, w_cpu_rvalid_nxt;
    logic              r_dma_rvalid, w_dma_rvalid_nxt;
    logic [DATA_W-1:0] r_cpu_rdata,  w_cpu_rdata_nxt;
    logic [DATA_W-1:0] r_dma_rdata,  w_dma_rdata_nxt;
    logic              r_win_dma,    w_win_dma_nxt;
    logic              r_ptr_dma,    w_ptr_dma_nxt;
    logic [3:0]        r_lock_cnt,   w_lock_cnt_nxt;

    logic              w_dma_wins;
    logic [3:0]        w_lock_inc;

    assign w_dma_wins = dma_req && (!cpu_req || r_ptr_dma);
    // Saturating so an uncontended DMA lock can run forever without wrapping
    assign w_lock_inc = (r_lock_cnt >= c_LOCK_MAX) ? c_LOCK_MAX : r_lock_cnt + 4'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_win_dma    <= 1'b0;
            r_ptr_dma    <= 1'b0;
            r_lock_cnt   <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_ram_en     <= w_ram_en_nxt;
            r_ram_we     <= w_ram_we_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_wdata  <= w_ram_wdata_nxt;
            r_cpu_gnt    <= w_cpu_gnt_nxt;
            r_dma_gnt    <= w_dma_gnt_nxt;
            r_cpu_rvalid <= w_cpu_rvalid_nxt;
            r_dma_rvalid <= w_dma_rvalid_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_dma_rdata  <= w_dma_rdata_nxt;
            r_win_dma    <= w_win_dma_nxt;
            r_ptr_dma    <= w_ptr_dma_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ram_en_nxt     = 1'b0;
        w_ram_we_nxt     = 1'b0;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_wdata_nxt  = r_ram_wdata;
        w_cpu_gnt_nxt    = 1'b0;
        w_dma_gnt_nxt    = 1'b0;
        w_cpu_rvalid_nxt = 1'b0;
        w_dma_rvalid_nxt = 1'b0;
        w_cpu_rdata_nxt  = r_cpu_rdata;
        w_dma_rdata_nxt  = r_dma_rdata;
        w_win_dma_nxt    = r_win_dma;
        w_ptr_dma_nxt    = r_ptr_dma;
        w_lock_cnt_nxt   = r_lock_cnt;

        case (r_state)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    w_state_nxt   = S_ACCESS;
                    w_ram_en_nxt  = 1'b1;
                    w_win_dma_nxt = w_dma_wins;
                    if (w_dma_wins) begin
                        w_ram_we_nxt    = dma_we;
                        w_ram_addr_nxt  = dma_addr;
                        w_ram_wdata_nxt = dma_wdata;
                        w_dma_gnt_nxt   = 1'b1;
                        if (dma_lock) begin
                            // Hand priority back once the CPU has waited out the burst bound
                            if ((w_lock_inc == c_LOCK_MAX) && cpu_req) begin
                                w_ptr_dma_nxt  = 1'b0;
                                w_lock_cnt_nxt = 4'd0;
                            end else begin
                                w_ptr_dma_nxt  = 1'b1;
                                w_lock_cnt_nxt = w_lock_inc;
                            end
                        end else begin
                            w_ptr_dma_nxt  = 1'b0;
                            w_lock_cnt_nxt = 4'd0;
                        end
                    end else begin
                        w_ram_we_nxt    = cpu_we;
                        w_ram_addr_nxt  = cpu_addr;
                        w_ram_wdata_nxt = cpu_wdata;
                        w_cpu_gnt_nxt   = 1'b1;
                        w_ptr_dma_nxt   = 1'b1;
                        w_lock_cnt_nxt  = 4'd0;
                    end
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_IDLE;
                if (!r_ram_we) begin
                    if (r_win_dma) begin
                        w_dma_rdata_nxt  = ram_rdata;
                        w_dma_rvalid_nxt = 1'b1;
                    end else begin
                        w_cpu_rdata_nxt  = ram_rdata;
                        w_cpu_rvalid_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign dma_gnt    = r_dma_gnt;
    assign dma_rvalid = r_dma_rvalid;
    assign dma_rdata  = r_dma_rdata;
    assign ram_en     = r_ram_en;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Scoreboard bench for ram_arbiter with a behavioural 1024x8 RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 4;

    typedef struct packed {
        logic              dma;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [ADDR_W-1:0] cpu_addr, dma_addr, ram_addr;
    logic [DATA_W-1:0] cpu_wdata, dma_wdata, ram_wdata, ram_rdata;
    logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_en, ram_we;
    logic [DATA_W-1:0] cpu_rdata, dma_rdata;

    logic [DATA_W-1:0] mem [0:1023];
    exp_t              sb[$];
    logic              rv_pend = 1'b0;
    logic              rv_dma  = 1'b0;
    logic [DATA_W-1:0] rv_data = '0;
    logic              reset_q;
    int                errors = 0;
    int                checks = 0;

    always #5 clock = ~clock;
    always @(posedge clock) reset_q <= reset;

    assign ram_rdata = mem[ram_addr];

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic d, input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd);
        exp_t e;
        e.dma = d; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd;
        sb.push_back(e);
    endtask

    // Scoreboard: runs once per falling edge, pops on every grant
    task automatic monitor();
        exp_t e;
        if (reset_q) rv_pend = 1'b0;
        checks++;
        if ((cpu_gnt && dma_gnt) || (cpu_rvalid && dma_rvalid) || (ram_we && !ram_en)
            || ((cpu_gnt || dma_gnt) !== ram_en)) begin
            errors++;
            $display("FAIL invariant: cpu_gnt=%0b dma_gnt=%0b cpu_rvalid=%0b dma_rvalid=%0b ram_en=%0b ram_we=%0b, want exclusive strobes with ram_en tied to gnt",
                     cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_en, ram_we);
        end
        if (rv_pend) begin
            checks++;
            if (cpu_rvalid !== !rv_dma || dma_rvalid !== rv_dma
                || (rv_dma ? dma_rdata : cpu_rdata) !== rv_data) begin
                errors++;
                $display("FAIL rvalid: cpu_rvalid=%0b dma_rvalid=%0b cpu_rdata=%h dma_rdata=%h, want dma=%0b data=%h",
                         cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, rv_dma, rv_data);
            end
        end else if (cpu_rvalid || dma_rvalid) begin
            checks++;
            errors++;
            $display("FAIL spurious_rvalid: cpu_rvalid=%0b dma_rvalid=%0b, want 0 0", cpu_rvalid, dma_rvalid);
        end
        rv_pend = 1'b0;
        if (cpu_gnt || dma_gnt) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_gnt: cpu_gnt=%0b dma_gnt=%0b addr=%h, want no grant", cpu_gnt, dma_gnt, ram_addr);
            end else begin
                e = sb.pop_front();
                if (dma_gnt !== e.dma || cpu_gnt !== !e.dma || ram_en !== 1'b1 || ram_we !== e.we
                    || ram_addr !== e.addr || ram_wdata !== e.wdata) begin
                    errors++;
                    $display("FAIL grant: got dma=%0b cpu=%0b en=%0b we=%0b addr=%h wdata=%h, want dma=%0b cpu=%0b en=1 we=%0b addr=%h wdata=%h",
                             dma_gnt, cpu_gnt, ram_en, ram_we, ram_addr, ram_wdata,
                             e.dma, !e.dma, e.we, e.addr, e.wdata);
                end
                if (!e.we) begin
                    rv_pend = 1'b1;
                    rv_dma  = e.dma;
                    rv_data = e.rdata;
                end
            end
        end
        if (ram_en && ram_we) mem[ram_addr] = ram_wdata;
    endtask

    task automatic step();
        @(negedge clock);
        monitor();
    endtask

    task automatic tick();
        step();
        #1;
    endtask

    task automatic drop_all();
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        cpu_we = 1'b0; dma_we = 1'b0; cpu_wdata = '0; dma_wdata = '0;
    endtask

    task automatic wait_sb(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d grants outstanding after %0d cycles, want 0", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic wait_done(input string name);
        wait_sb(40, name);
        repeat (2) tick();
    endtask

    task automatic apply_reset();
        drop_all();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic do_req(input logic d, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd, input string name);
        push_exp(d, w, a, wd, rd);
        if (d) begin
            dma_req = 1'b1; dma_we = w; dma_addr = a; dma_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
        end
        wait_sb(20, name);
        drop_all();
        wait_done(name);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        step();
        checks++;
        if ({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_en, ram_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, want 000000",
                     {cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_en, ram_we});
        end
        checks++;
        if (cpu_rdata !== 8'h00 || dma_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got cpu=%h dma=%h, want 00 00", cpu_rdata, dma_rdata);
        end
        checks++;
        if (ram_addr !== 10'h000 || ram_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h, want 000 00", ram_addr, ram_wdata);
        end
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        push_exp(1'b0, 1'b0, 10'h005, 8'h00, 8'hA7);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005; cpu_wdata = 8'h00;
        step();
        checks++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'h005) begin
            errors++;
            $display("FAIL cpu_read_n1: got gnt=%0b dma_gnt=%0b en=%0b we=%0b addr=%h, want 1 0 1 0 005",
                     cpu_gnt, dma_gnt, ram_en, ram_we, ram_addr);
        end
        #1;
        drop_all();
        step();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA7 || cpu_gnt !== 1'b0 || dma_rvalid !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_n2: got rvalid=%0b rdata=%h gnt=%0b dma_rvalid=%0b en=%0b, want 1 a7 0 0 0",
                     cpu_rvalid, cpu_rdata, cpu_gnt, dma_rvalid, ram_en);
        end
        #1;
        wait_done("cpu_read");
    endtask

    task automatic test_round_robin();
        int cyc = 0;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 1'b0, 10'h010, 8'h00, 8'h11);
            push_exp(1'b1, 1'b0, 10'h020, 8'h00, 8'h22);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h020;
        while (sb.size() != 0 && cyc < 30) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 7) begin
            errors++;
            $display("FAIL rr_spacing: fourth grant after %0d cycles, want 7", cyc);
        end
        sb.delete();
        drop_all();
        wait_done("round_robin");
    endtask

    task automatic test_write_read();
        do_req(1'b1, 1'b1, 10'h3C0, 8'h55, 8'h00, "dma_write");
        checks++;
        if (mem[10'h3C0] !== 8'h55 || cpu_rdata !== 8'h11 || dma_rdata !== 8'h22) begin
            errors++;
            $display("FAIL write_effect: got mem=%h cpu_rdata=%h dma_rdata=%h, want 55 11 22",
                     mem[10'h3C0], cpu_rdata, dma_rdata);
        end
        do_req(1'b0, 1'b0, 10'h3C0, 8'h00, 8'h55, "cpu_readback");
        checks++;
        if (cpu_rdata !== 8'h55 || dma_rdata !== 8'h22) begin
            errors++;
            $display("FAIL readback_hold: got cpu_rdata=%h dma_rdata=%h, want 55 22", cpu_rdata, dma_rdata);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        push_exp(1'b0, 1'b0, 10'h010, 8'h00, 8'h11);
        for (int i = 0; i < LOCK_MAX; i++) push_exp(1'b1, 1'b0, 10'h020, 8'h00, 8'h22);
        push_exp(1'b0, 1'b0, 10'h010, 8'h00, 8'h11);
        push_exp(1'b1, 1'b0, 10'h020, 8'h00, 8'h22);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h020; dma_lock = 1'b1;
        wait_sb(40, "lock_contended");
        drop_all();
        wait_done("lock_contended");

        apply_reset();
        for (int i = 0; i < 10; i++) push_exp(1'b1, 1'b0, 10'h020, 8'h00, 8'h22);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h020; dma_lock = 1'b1;
        wait_sb(40, "lock_free");
        // Saturated counter: one more DMA grant, then the CPU gets through
        push_exp(1'b1, 1'b0, 10'h020, 8'h00, 8'h22);
        push_exp(1'b0, 1'b0, 10'h010, 8'h00, 8'h11);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        wait_sb(20, "lock_release");
        drop_all();
        wait_done("lock_release");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({ram_en, ram_we, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid} !== 6'b0) begin
                errors++;
                $display("FAIL idle_strobes: cycle %0d got %b, want 000000", i,
                         {ram_en, ram_we, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid});
            end
            #1;
        end
    endtask

    task automatic test_reset_in_access();
        push_exp(1'b0, 1'b0, 10'h005, 8'h00, 8'hA7);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        step();
        checks++;
        if (cpu_gnt !== 1'b1 || ram_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_access_gnt: got gnt=%0b en=%0b, want 1 1", cpu_gnt, ram_en);
        end
        #1;
        drop_all();
        reset = 1'b1;
        step();
        checks++;
        if ({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_en, ram_we} !== 6'b0
            || cpu_rdata !== 8'h00 || dma_rdata !== 8'h00 || ram_addr !== 10'h000 || ram_wdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_access_outputs: got strobes=%b cpu_rdata=%h dma_rdata=%h addr=%h wdata=%h, want all 0",
                     {cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_en, ram_we},
                     cpu_rdata, dma_rdata, ram_addr, ram_wdata);
        end
        #1;
        reset = 1'b0;
        push_exp(1'b0, 1'b0, 10'h010, 8'h00, 8'h11);
        push_exp(1'b1, 1'b0, 10'h020, 8'h00, 8'h22);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h020;
        wait_sb(20, "post_reset");
        drop_all();
        wait_done("post_reset");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h005] = 8'hA7;
        mem[10'h010] = 8'h11;
        mem[10'h020] = 8'h22;
        reset = 1'b1;
        cpu_addr = '0;
        dma_addr = '0;
        drop_all();

        test_reset();
        test_cpu_read();
        test_round_robin();
        test_write_read();
        test_lock();
        test_idle();
        test_reset_in_access();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
